// File: rtl/fw_cmd_decoder_if.sv
// Command/dispatch bundle between the host-side driver and fw_cmd_decoder.
// master = host and downstream environment, slave = the decoder itself.
interface fw_cmd_decoder_if;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [23:0] cfg_static_0_reg;
    logic [23:0] cfg_static_1_reg;
    logic        array_wr_valid;
    logic [1:0]  array_wr_sel;
    logic [23:0] array_wr_data;
    logic        array_wr_ready;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic        rd_resp_valid;
    logic [23:0] rd_resp_data;
    logic [23:0] rd_data;
    logic        execute_start;
    logic [23:0] execute_cfg;
    logic        test_busy;
    logic [3:0]  test_done;
    logic        fw_soft_rst;
    logic [31:0] status;

    modport master (
        output wr_valid, wr_data, array_wr_ready, rd_resp_valid, rd_resp_data,
               test_busy, test_done,
        input  wr_ready, cfg_static_0_reg, cfg_static_1_reg, array_wr_valid,
               array_wr_sel, array_wr_data, rd_req, rd_sel, rd_data,
               execute_start, execute_cfg, fw_soft_rst, status
    );

    modport slave (
        input  wr_valid, wr_data, array_wr_ready, rd_resp_valid, rd_resp_data,
               test_busy, test_done,
        output wr_ready, cfg_static_0_reg, cfg_static_1_reg, array_wr_valid,
               array_wr_sel, array_wr_data, rd_req, rd_sel, rd_data,
               execute_start, execute_cfg, fw_soft_rst, status
    );
endinterface

// File: rtl/fw_cmd_decoder.sv
// Firmware command front-end: filters host command words by device id, decodes
// the op code and dispatches static/array/read/execute/soft-reset actions.
module fw_cmd_decoder #(
    parameter logic [3:0]  FIRMWARE_ID     = 4'h1,
    parameter int unsigned TEST_NUMBER_LSB = 14,
    parameter int unsigned RST_CYCLES      = 8,
    parameter int unsigned RD_TIMEOUT      = 255
) (
    input  logic            fw_axi_clk,
    input  logic            fw_rst,
    fw_cmd_decoder_if.slave bus
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DISPATCH, S_ARRAY_PUSH, S_READ_WAIT, S_SOFT_RST
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP         = 4'h0, OP_RST_FW       = 4'h1,
        OP_W_STATIC_0   = 4'h2, OP_R_STATIC_0   = 4'h3,
        OP_W_STATIC_1   = 4'h4, OP_R_STATIC_1   = 4'h5,
        OP_W_ARRAY_0    = 4'h6, OP_R_ARRAY_0    = 4'h7,
        OP_W_ARRAY_1    = 4'h8, OP_R_ARRAY_1    = 4'h9,
        OP_W_ARRAY_2    = 4'hA, OP_R_ARRAY_2    = 4'hB,
        OP_R_DATA_0     = 4'hC, OP_R_DATA_1     = 4'hD,
        OP_STATUS_CLEAR = 4'hE, OP_EXECUTE      = 4'hF
    } op_t;

    state_t           r_state,      w_state_nxt;
    logic [31:0]      r_cmd,        w_cmd_nxt;
    logic [CNT_W-1:0] r_cnt,        w_cnt_nxt;
    logic             r_wr_ready,   w_wr_ready_nxt;
    logic [23:0]      r_static_0,   w_static_0_nxt;
    logic [23:0]      r_static_1,   w_static_1_nxt;
    logic             r_arr_valid,  w_arr_valid_nxt;
    logic [1:0]       r_arr_sel,    w_arr_sel_nxt;
    logic [23:0]      r_arr_data,   w_arr_data_nxt;
    logic             r_rd_req,     w_rd_req_nxt;
    logic [2:0]       r_rd_sel,     w_rd_sel_nxt;
    logic [23:0]      r_rd_data,    w_rd_data_nxt;
    logic             r_exec_start, w_exec_start_nxt;
    logic [23:0]      r_exec_cfg,   w_exec_cfg_nxt;
    logic             r_soft_rst,   w_soft_rst_nxt;
    logic [31:0]      r_status,     w_status_nxt;

    logic [31:0] w_status_set;
    logic        w_status_clr;
    logic [3:0]  w_dev;
    op_t         w_op;
    logic [23:0] w_body;
    logic [3:0]  w_tn;
    logic [4:0]  w_op_bit;

    assign w_dev    = r_cmd[31:28];
    assign w_op     = op_t'(r_cmd[27:24]);
    assign w_body   = r_cmd[23:0];
    assign w_tn     = w_body[TEST_NUMBER_LSB +: 4];
    // Completion bit for ops 2..13 sits one below the op code
    assign w_op_bit = 5'(r_cmd[27:24]) - 5'd1;

    always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
        if (fw_rst) begin
            r_state      <= S_IDLE;
            r_cmd        <= '0;
            r_cnt        <= '0;
            r_wr_ready   <= 1'b1;
            r_static_0   <= '0;
            r_static_1   <= '0;
            r_arr_valid  <= 1'b0;
            r_arr_sel    <= '0;
            r_arr_data   <= '0;
            r_rd_req     <= 1'b0;
            r_rd_sel     <= '0;
            r_rd_data    <= '0;
            r_exec_start <= 1'b0;
            r_exec_cfg   <= '0;
            r_soft_rst   <= 1'b0;
            r_status     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd        <= w_cmd_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wr_ready   <= w_wr_ready_nxt;
            r_static_0   <= w_static_0_nxt;
            r_static_1   <= w_static_1_nxt;
            r_arr_valid  <= w_arr_valid_nxt;
            r_arr_sel    <= w_arr_sel_nxt;
            r_arr_data   <= w_arr_data_nxt;
            r_rd_req     <= w_rd_req_nxt;
            r_rd_sel     <= w_rd_sel_nxt;
            r_rd_data    <= w_rd_data_nxt;
            r_exec_start <= w_exec_start_nxt;
            r_exec_cfg   <= w_exec_cfg_nxt;
            r_soft_rst   <= w_soft_rst_nxt;
            r_status     <= w_status_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cmd_nxt        = r_cmd;
        w_cnt_nxt        = r_cnt;
        w_static_0_nxt   = r_static_0;
        w_static_1_nxt   = r_static_1;
        w_arr_valid_nxt  = r_arr_valid;
        w_arr_sel_nxt    = r_arr_sel;
        w_arr_data_nxt   = r_arr_data;
        w_rd_req_nxt     = 1'b0;
        w_rd_sel_nxt     = r_rd_sel;
        w_rd_data_nxt    = r_rd_data;
        w_exec_start_nxt = 1'b0;
        w_exec_cfg_nxt   = r_exec_cfg;
        w_soft_rst_nxt   = r_soft_rst;
        w_status_set     = '0;
        w_status_clr     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.wr_valid) begin
                    w_cmd_nxt   = bus.wr_data;
                    w_state_nxt = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                w_state_nxt = S_IDLE;
                if (w_dev == FIRMWARE_ID) begin
                    case (w_op)
                        OP_RST_FW: begin
                            w_static_0_nxt = '0;
                            w_static_1_nxt = '0;
                            w_exec_cfg_nxt = '0;
                            w_rd_data_nxt  = '0;
                            w_status_clr   = 1'b1;
                            w_soft_rst_nxt = 1'b1;
                            w_cnt_nxt      = '0;
                            w_state_nxt    = S_SOFT_RST;
                        end
                        OP_W_STATIC_0: begin
                            w_static_0_nxt         = w_body;
                            w_status_set[w_op_bit] = 1'b1;
                        end
                        OP_W_STATIC_1: begin
                            w_static_1_nxt         = w_body;
                            w_status_set[w_op_bit] = 1'b1;
                        end
                        OP_R_STATIC_0: begin
                            w_rd_data_nxt          = r_static_0;
                            w_status_set[w_op_bit] = 1'b1;
                        end
                        OP_R_STATIC_1: begin
                            w_rd_data_nxt          = r_static_1;
                            w_status_set[w_op_bit] = 1'b1;
                        end
                        OP_W_ARRAY_0, OP_W_ARRAY_1, OP_W_ARRAY_2: begin
                            w_arr_valid_nxt = 1'b1;
                            w_arr_data_nxt  = w_body;
                            w_arr_sel_nxt   = (w_op == OP_W_ARRAY_0) ? 2'd0 :
                                              (w_op == OP_W_ARRAY_1) ? 2'd1 : 2'd2;
                            w_state_nxt     = S_ARRAY_PUSH;
                        end
                        OP_R_ARRAY_0, OP_R_ARRAY_1, OP_R_ARRAY_2,
                        OP_R_DATA_0, OP_R_DATA_1: begin
                            w_rd_req_nxt = 1'b1;
                            w_cnt_nxt    = '0;
                            w_state_nxt  = S_READ_WAIT;
                            case (w_op)
                                OP_R_ARRAY_0: w_rd_sel_nxt = 3'd0;
                                OP_R_ARRAY_1: w_rd_sel_nxt = 3'd1;
                                OP_R_ARRAY_2: w_rd_sel_nxt = 3'd2;
                                OP_R_DATA_0:  w_rd_sel_nxt = 3'd3;
                                default:      w_rd_sel_nxt = 3'd4;
                            endcase
                        end
                        OP_STATUS_CLEAR: w_status_clr = 1'b1;
                        OP_EXECUTE: begin
                            // Start only a single, idle test; anything else is an error
                            if ($onehot(w_tn) && !bus.test_busy) begin
                                w_exec_cfg_nxt   = w_body;
                                w_exec_start_nxt = 1'b1;
                                w_status_set[13] = 1'b1;
                            end else begin
                                w_status_set[31] = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_ARRAY_PUSH: begin
                if (bus.array_wr_ready) begin
                    w_arr_valid_nxt        = 1'b0;
                    w_status_set[w_op_bit] = 1'b1;
                    w_state_nxt            = S_IDLE;
                end
            end
            S_READ_WAIT: begin
                if (bus.rd_resp_valid) begin
                    w_rd_data_nxt          = bus.rd_resp_data;
                    w_status_set[w_op_bit] = 1'b1;
                    w_state_nxt            = S_IDLE;
                end else if (r_cnt == RD_LAST) begin
                    w_rd_data_nxt    = '0;
                    w_status_set[31] = 1'b1;
                    w_state_nxt      = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SOFT_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_soft_rst_nxt  = 1'b0;
                    w_status_set[0] = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // test_done is applied after a clear so a coincident done pulse survives
        w_status_nxt = (w_status_clr ? 32'd0 : r_status) | w_status_set
                     | {14'd0, bus.test_done, 14'd0};
        w_status_nxt[30:18] = '0;
        w_wr_ready_nxt      = (w_state_nxt == S_IDLE);
    end

    assign bus.wr_ready         = r_wr_ready;
    assign bus.cfg_static_0_reg = r_static_0;
    assign bus.cfg_static_1_reg = r_static_1;
    assign bus.array_wr_valid   = r_arr_valid;
    assign bus.array_wr_sel     = r_arr_sel;
    assign bus.array_wr_data    = r_arr_data;
    assign bus.rd_req           = r_rd_req;
    assign bus.rd_sel           = r_rd_sel;
    assign bus.rd_data          = r_rd_data;
    assign bus.execute_start    = r_exec_start;
    assign bus.execute_cfg      = r_exec_cfg;
    assign bus.fw_soft_rst      = r_soft_rst;
    assign bus.status           = r_status;
endmodule
